// File: rtl/seq_trace_decoder_pkg.sv
// Shared definitions for the lab6 sequencer trace decoder: state codes, monitor states, step legality.
// Optional error capture is enabled with SEQ_TRACE_ERR_CAPTURE_EN (see seq_trace_decoder).
package seq_trace_pkg;

    localparam logic [3:0] Y0 = 4'd0;
    localparam logic [3:0] Y1 = 4'd1;
    localparam logic [3:0] Y2 = 4'd2;
    localparam logic [3:0] Y3 = 4'd3;
    localparam logic [3:0] Y4 = 4'd4;
    localparam logic [3:0] Y5 = 4'd5;
    localparam logic [3:0] Y6 = 4'd6;
    localparam logic [3:0] Y7 = 4'd7;
    localparam logic [3:0] Y8 = 4'd8;
    localparam logic [3:0] Y9 = 4'd9;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        ERR   = 2'd2
    } monitor_state_e;

    // Edges of the sequencer graph; repeats and codes 10..15 fall through to illegal.
    function automatic logic is_legal_step(input logic [3:0] prev, input logic [3:0] cur);
        logic ok;
        ok = 1'b0;
        case ({prev, cur})
            {Y0, Y1}, {Y1, Y2}, {Y1, Y4}, {Y2, Y3},
            {Y3, Y7}, {Y4, Y5}, {Y5, Y6}, {Y5, Y4},
            {Y6, Y8}, {Y7, Y8}, {Y8, Y9}, {Y9, Y0}: ok = 1'b1;
            default:                                ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/seq_trace_decoder_if.sv
// Sample/result bundle between the sequencer side and the trace decoder.
// Capture ports exist only when SEQ_TRACE_ERR_CAPTURE_EN is defined.
interface seq_trace_decoder_if #(parameter int LOOP_W = 8);

    logic              i_valid;
    logic [3:0]        i_code;
    logic              i_err_clr;
    logic              o_x1;
    logic              o_x1_vld;
    logic              o_x2;
    logic              o_x2_vld;
    logic              o_done;
    logic              o_abort;
    logic              o_err;
    logic [LOOP_W-1:0] o_loop_cnt;
    logic              o_loop_ovf;
    logic [1:0]        o_state;
`ifdef SEQ_TRACE_ERR_CAPTURE_EN
    logic [3:0]        o_err_prev;
    logic [3:0]        o_err_cur;

    modport master (
        output i_valid, i_code, i_err_clr,
        input  o_x1, o_x1_vld, o_x2, o_x2_vld, o_done, o_abort, o_err,
               o_loop_cnt, o_loop_ovf, o_state, o_err_prev, o_err_cur
    );

    modport slave (
        input  i_valid, i_code, i_err_clr,
        output o_x1, o_x1_vld, o_x2, o_x2_vld, o_done, o_abort, o_err,
               o_loop_cnt, o_loop_ovf, o_state, o_err_prev, o_err_cur
    );
`else
    modport master (
        output i_valid, i_code, i_err_clr,
        input  o_x1, o_x1_vld, o_x2, o_x2_vld, o_done, o_abort, o_err,
               o_loop_cnt, o_loop_ovf, o_state
    );

    modport slave (
        input  i_valid, i_code, i_err_clr,
        output o_x1, o_x1_vld, o_x2, o_x2_vld, o_done, o_abort, o_err,
               o_loop_cnt, o_loop_ovf, o_state
    );
`endif

endinterface

// File: rtl/seq_trace_decoder_step_checker.sv
// Combinational classifier for one prev->cur step of the sequencer trace.
module seq_step_checker
    import seq_trace_pkg::*;
(
    input  logic [3:0] prev_i,
    input  logic [3:0] cur_i,
    output logic       legal_o,
    output logic       early_zero_o,
    output logic       x1_step_o,
    output logic       x2_step_o,
    output logic       loop_step_o,
    output logic       done_step_o
);

    always_comb begin
        legal_o      = is_legal_step(prev_i, cur_i);
        // A return to Y0 from anywhere but Y9 means the sequencer was reset upstream.
        early_zero_o = (cur_i == Y0) && (prev_i != Y9);
        x1_step_o    = legal_o && (prev_i == Y1);
        x2_step_o    = legal_o && (prev_i == Y5);
        loop_step_o  = (prev_i == Y5) && (cur_i == Y4);
        done_step_o  = (prev_i == Y8) && (cur_i == Y9);
    end

endmodule

// File: rtl/seq_trace_decoder.sv
// Monitor for the lab6 sequencer code stream: recovers X1/X2, counts Y5->Y4 retries, flags illegal steps.
// Define SEQ_TRACE_ERR_CAPTURE_EN to latch {prev, cur} of the first illegal step.
module seq_trace_decoder
    import seq_trace_pkg::*;
#(
    parameter int LOOP_W    = 8,
    parameter int MAX_LOOPS = 200
) (
    input  logic                i_clk,
    input  logic                i_rst,
    seq_trace_decoder_if.slave  bus
);

    localparam logic [LOOP_W-1:0] MAX_LOOPS_W = LOOP_W'(MAX_LOOPS);

    monitor_state_e    state_q;
    logic [3:0]        prevCode_q;
    logic [LOOP_W-1:0] loopCnt_q;
    logic              x1_q, x1Vld_q, x2_q, x2Vld_q;
    logic              done_q, abort_q, err_q, loopOvf_q;
`ifdef SEQ_TRACE_ERR_CAPTURE_EN
    logic [3:0]        errPrev_q;
    logic [3:0]        errCur_q;
`endif

    logic              legal, earlyZero, x1Step, x2Step, loopStep, doneStep;
    logic [LOOP_W-1:0] loopCnt_d;
    logic              ovfHit;

    seq_step_checker u_checker (
        .prev_i       (prevCode_q),
        .cur_i        (bus.i_code),
        .legal_o      (legal),
        .early_zero_o (earlyZero),
        .x1_step_o    (x1Step),
        .x2_step_o    (x2Step),
        .loop_step_o  (loopStep),
        .done_step_o  (doneStep)
    );

    // Saturating retry increment; overflow only fires on a real increment landing on MAX_LOOPS.
    always_comb begin
        loopCnt_d = loopCnt_q;
        ovfHit    = 1'b0;
        if (loopCnt_q != {LOOP_W{1'b1}}) begin
            loopCnt_d = loopCnt_q + 1'b1;
            ovfHit    = (loopCnt_d == MAX_LOOPS_W);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= SYNC;
            prevCode_q <= Y0;
            loopCnt_q  <= '0;
            x1_q       <= 1'b0;
            x1Vld_q    <= 1'b0;
            x2_q       <= 1'b0;
            x2Vld_q    <= 1'b0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
            err_q      <= 1'b0;
            loopOvf_q  <= 1'b0;
`ifdef SEQ_TRACE_ERR_CAPTURE_EN
            errPrev_q  <= 4'd0;
            errCur_q   <= 4'd0;
`endif
        end else begin
            x1Vld_q <= 1'b0;
            x2Vld_q <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            // Clear comes first so that a same-cycle set below takes priority.
            if (bus.i_err_clr) begin
                err_q     <= 1'b0;
                loopOvf_q <= 1'b0;
            end
            case (state_q)
                SYNC: begin
                    if (bus.i_valid && (bus.i_code == Y0)) begin
                        prevCode_q <= Y0;
                        loopCnt_q  <= '0;
                        state_q    <= TRACK;
                    end
                end
                TRACK: begin
                    if (bus.i_valid) begin
                        if (legal) begin
                            prevCode_q <= bus.i_code;
                            if (x1Step) begin
                                x1_q    <= (bus.i_code == Y4);
                                x1Vld_q <= 1'b1;
                            end
                            if (x2Step) begin
                                x2_q    <= (bus.i_code == Y6);
                                x2Vld_q <= 1'b1;
                            end
                            if (loopStep) begin
                                loopCnt_q <= loopCnt_d;
                                if (ovfHit) begin
                                    loopOvf_q <= 1'b1;
                                end
                            end
                            if (doneStep) begin
                                done_q <= 1'b1;
                            end
                            if (bus.i_code == Y0) begin
                                loopCnt_q <= '0;
                            end
                        end else if (earlyZero) begin
                            abort_q    <= 1'b1;
                            loopCnt_q  <= '0;
                            prevCode_q <= Y0;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= ERR;
`ifdef SEQ_TRACE_ERR_CAPTURE_EN
                            if (!err_q || bus.i_err_clr) begin
                                errPrev_q <= prevCode_q;
                                errCur_q  <= bus.i_code;
                            end
`endif
                        end
                    end
                end
                ERR: begin
                    state_q <= SYNC;
                end
                default: begin
                    state_q <= SYNC;
                end
            endcase
        end
    end

    assign bus.o_x1       = x1_q;
    assign bus.o_x1_vld   = x1Vld_q;
    assign bus.o_x2       = x2_q;
    assign bus.o_x2_vld   = x2Vld_q;
    assign bus.o_done     = done_q;
    assign bus.o_abort    = abort_q;
    assign bus.o_err      = err_q;
    assign bus.o_loop_cnt = loopCnt_q;
    assign bus.o_loop_ovf = loopOvf_q;
    assign bus.o_state    = state_q;
`ifdef SEQ_TRACE_ERR_CAPTURE_EN
    assign bus.o_err_prev = errPrev_q;
    assign bus.o_err_cur  = errCur_q;
`endif

endmodule

// File: tb/tb_seq_trace_decoder.sv
// Directed bench for seq_trace_decoder: a default instance plus a LOOP_W=2/MAX_LOOPS=3 instance for overflow.
// Capture checks run when SEQ_TRACE_ERR_CAPTURE_EN is defined.
module tb_seq_trace_decoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    seq_trace_decoder_if #(.LOOP_W(8)) bus ();
    seq_trace_decoder_if #(.LOOP_W(2)) busS ();

    seq_trace_decoder #(.LOOP_W(8), .MAX_LOOPS(200)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    seq_trace_decoder #(.LOOP_W(2), .MAX_LOOPS(3)) dutS (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (busS.slave)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Both instances see the same stimulus; outputs are sampled 1 time unit after the edge.
    task automatic applyStimulus(input logic v, input logic [3:0] c, input logic clr);
        bus.i_valid    = v;
        bus.i_code     = c;
        bus.i_err_clr  = clr;
        busS.i_valid   = v;
        busS.i_code    = c;
        busS.i_err_clr = clr;
        @(posedge clk);
        #1;
        bus.i_valid    = 1'b0;
        bus.i_err_clr  = 1'b0;
        busS.i_valid   = 1'b0;
        busS.i_err_clr = 1'b0;
    endtask

    task automatic sendCode(input logic [3:0] c);
        applyStimulus(1'b1, c, 1'b0);
    endtask

    task automatic gap();
        applyStimulus(1'b0, 4'd0, 1'b0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_x1"},    {31'd0, bus.o_x1},     0);
        checkOutput({tag, "_x1v"},   {31'd0, bus.o_x1_vld}, 0);
        checkOutput({tag, "_x2"},    {31'd0, bus.o_x2},     0);
        checkOutput({tag, "_x2v"},   {31'd0, bus.o_x2_vld}, 0);
        checkOutput({tag, "_done"},  {31'd0, bus.o_done},   0);
        checkOutput({tag, "_abort"}, {31'd0, bus.o_abort},  0);
        checkOutput({tag, "_err"},   {31'd0, bus.o_err},    0);
        checkOutput({tag, "_loop"},  {24'd0, bus.o_loop_cnt}, 0);
        checkOutput({tag, "_ovf"},   {31'd0, bus.o_loop_ovf}, 0);
        checkOutput({tag, "_state"}, {30'd0, bus.o_state},  0);
        checkOutput({tag, "_sloop"}, {30'd0, busS.o_loop_cnt}, 0);
        checkOutput({tag, "_sovf"},  {31'd0, busS.o_loop_ovf}, 0);
`ifdef SEQ_TRACE_ERR_CAPTURE_EN
        checkOutput({tag, "_eprev"}, {28'd0, bus.o_err_prev}, 0);
        checkOutput({tag, "_ecur"},  {28'd0, bus.o_err_cur},  0);
`endif
    endtask

    initial begin
        bus.i_valid = 1'b0;  bus.i_code = 4'd0;  bus.i_err_clr = 1'b0;
        busS.i_valid = 1'b0; busS.i_code = 4'd0; busS.i_err_clr = 1'b0;
        #12;
        checkAllZero("reset");
        rst = 1'b0;

        // Sync, then X1=0 path
        sendCode(4'd5);  checkOutput("sync_discard", {30'd0, bus.o_state}, 0);
        sendCode(4'd0);  checkOutput("sync_enter", {30'd0, bus.o_state}, 1);
        sendCode(4'd1);  checkOutput("p0_x1v_early", {31'd0, bus.o_x1_vld}, 0);
        sendCode(4'd2);  checkOutput("p0_x1v", {31'd0, bus.o_x1_vld}, 1);
                         checkOutput("p0_x1", {31'd0, bus.o_x1}, 0);
        sendCode(4'd3);
        sendCode(4'd7);
        sendCode(4'd8);  checkOutput("p0_done_early", {31'd0, bus.o_done}, 0);
        sendCode(4'd9);  checkOutput("p0_done", {31'd0, bus.o_done}, 1);
                         checkOutput("p0_err", {31'd0, bus.o_err}, 0);
                         checkOutput("p0_loop", {24'd0, bus.o_loop_cnt}, 0);
        sendCode(4'd0);  checkOutput("p0_wrap_state", {30'd0, bus.o_state}, 1);
                         checkOutput("p0_wrap_abort", {31'd0, bus.o_abort}, 0);

        // X1=1 path with three retries
        sendCode(4'd1);
        sendCode(4'd4);  checkOutput("p1_x1v", {31'd0, bus.o_x1_vld}, 1);
                         checkOutput("p1_x1", {31'd0, bus.o_x1}, 1);
        for (int k = 1; k <= 3; k++) begin
            sendCode(4'd5);
            sendCode(4'd4);
            checkOutput("p1_retry_x2v", {31'd0, bus.o_x2_vld}, 1);
            checkOutput("p1_retry_x2", {31'd0, bus.o_x2}, 0);
            checkOutput("p1_retry_loop", {24'd0, bus.o_loop_cnt}, k);
        end
        sendCode(4'd5);
        sendCode(4'd6);  checkOutput("p1_x2v", {31'd0, bus.o_x2_vld}, 1);
                         checkOutput("p1_x2", {31'd0, bus.o_x2}, 1);
                         checkOutput("p1_loop", {24'd0, bus.o_loop_cnt}, 3);
        sendCode(4'd8);
        sendCode(4'd9);  checkOutput("p1_done", {31'd0, bus.o_done}, 1);
        sendCode(4'd0);  checkOutput("p1_loop_clr", {24'd0, bus.o_loop_cnt}, 0);

        // Illegal step 1->3
        sendCode(4'd1);
        sendCode(4'd3);  checkOutput("ill_err", {31'd0, bus.o_err}, 1);
                         checkOutput("ill_state", {30'd0, bus.o_state}, 2);
`ifdef SEQ_TRACE_ERR_CAPTURE_EN
                         checkOutput("ill_eprev", {28'd0, bus.o_err_prev}, 1);
                         checkOutput("ill_ecur", {28'd0, bus.o_err_cur}, 3);
`endif
        sendCode(4'd0);  checkOutput("ill_err_discard", {30'd0, bus.o_state}, 0);
        sendCode(4'd0);  checkOutput("ill_resync", {30'd0, bus.o_state}, 1);
                         checkOutput("ill_err_sticky", {31'd0, bus.o_err}, 1);
        applyStimulus(1'b0, 4'd0, 1'b1);
                         checkOutput("ill_clr", {31'd0, bus.o_err}, 0);
                         checkOutput("ill_clr_state", {30'd0, bus.o_state}, 1);

        // Early zero after one retry
        sendCode(4'd1); sendCode(4'd4); sendCode(4'd5); sendCode(4'd4);
        sendCode(4'd5);  checkOutput("ez_loop_pre", {24'd0, bus.o_loop_cnt}, 1);
        sendCode(4'd0);  checkOutput("ez_abort", {31'd0, bus.o_abort}, 1);
                         checkOutput("ez_err", {31'd0, bus.o_err}, 0);
                         checkOutput("ez_loop", {24'd0, bus.o_loop_cnt}, 0);
                         checkOutput("ez_state", {30'd0, bus.o_state}, 1);

        // Gapped legal path
        sendCode(4'd1);
        gap();           checkOutput("gap_x1v_idle", {31'd0, bus.o_x1_vld}, 0);
        gap();
        sendCode(4'd2);  checkOutput("gap_x1v", {31'd0, bus.o_x1_vld}, 1);
                         checkOutput("gap_x1", {31'd0, bus.o_x1}, 0);
        gap();
        sendCode(4'd3); sendCode(4'd7); gap(); sendCode(4'd8);
        sendCode(4'd9);  checkOutput("gap_done", {31'd0, bus.o_done}, 1);
        gap();           checkOutput("gap_done_idle", {31'd0, bus.o_done}, 0);
                         checkOutput("gap_err", {31'd0, bus.o_err}, 0);
        sendCode(4'd0);

        // Repeated code
        sendCode(4'd1); sendCode(4'd2);
        sendCode(4'd2);  checkOutput("rep_err", {31'd0, bus.o_err}, 1);
                         checkOutput("rep_state", {30'd0, bus.o_state}, 2);
`ifdef SEQ_TRACE_ERR_CAPTURE_EN
                         checkOutput("rep_eprev", {28'd0, bus.o_err_prev}, 2);
                         checkOutput("rep_ecur", {28'd0, bus.o_err_cur}, 2);
`endif
        gap();
        applyStimulus(1'b1, 4'd0, 1'b1);
                         checkOutput("bad_pre_err", {31'd0, bus.o_err}, 0);
        sendCode(4'd12); checkOutput("bad_err", {31'd0, bus.o_err}, 1);
`ifdef SEQ_TRACE_ERR_CAPTURE_EN
                         checkOutput("bad_ecur", {28'd0, bus.o_err_cur}, 12);
`endif
        gap(); sendCode(4'd0); sendCode(4'd1);
        sendCode(4'd3);  checkOutput("second_err", {31'd0, bus.o_err}, 1);
`ifdef SEQ_TRACE_ERR_CAPTURE_EN
                         checkOutput("keep_eprev", {28'd0, bus.o_err_prev}, 0);
                         checkOutput("keep_ecur", {28'd0, bus.o_err_cur}, 12);
`endif
        gap(); sendCode(4'd0);
        applyStimulus(1'b1, 4'd3, 1'b1);
                         checkOutput("clr_vs_set", {31'd0, bus.o_err}, 1);

        // Async reset between edges
        #2 rst = 1'b1;
        #1 checkAllZero("arst1");
        rst = 1'b0;

        // Overflow on the small instance
        sendCode(4'd0); sendCode(4'd1); sendCode(4'd4);
        for (int k = 1; k <= 4; k++) begin
            sendCode(4'd5);
            sendCode(4'd4);
            checkOutput("ovf_sloop", {30'd0, busS.o_loop_cnt}, (k < 3) ? k : 3);
            checkOutput("ovf_sflag", {31'd0, busS.o_loop_ovf}, (k >= 3) ? 1 : 0);
            checkOutput("ovf_loop", {24'd0, bus.o_loop_cnt}, k);
        end
        checkOutput("ovf_main_flag", {31'd0, bus.o_loop_ovf}, 0);
        applyStimulus(1'b0, 4'd0, 1'b1);
        checkOutput("ovf_clr", {31'd0, busS.o_loop_ovf}, 0);
        checkOutput("ovf_clr_loop", {30'd0, busS.o_loop_cnt}, 3);
        sendCode(4'd5);
        #2 rst = 1'b1;
        #1 checkAllZero("arst2");
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_trace_decoder.md
Name: seq_trace_decoder

Overview:
- Receiver and decoder for the 4-bit state-code stream produced by the lab6 ten-state sequencer (codes Y0..Y9).
- Samples one code per valid cycle and checks each step against the sequencer's transition graph.
- Recovers the X1/X2 branch decisions from the observed path, counts Y5->Y4 retry loops, and flags illegal steps.
- Sits downstream of the sequencer as a self-checking monitor and decision recovery stage.

Parameters:
- LOOP_W, 8, width of the retry-loop counter; the counter saturates.
- MAX_LOOPS, 200, loop count at which o_loop_ovf asserts; must be at most 2^LOOP_W-1.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous reset, active-high
- i_valid  in  1  i_code is sampled this cycle
- i_code  in  4  state code from the sequencer
- i_err_clr  in  1  clears sticky o_err and o_loop_ovf
- o_x1  out  1  recovered X1 decision; meaningful when o_x1_vld=1
- o_x1_vld  out  1  one-cycle pulse
- o_x2  out  1  recovered X2 decision; meaningful when o_x2_vld=1
- o_x2_vld  out  1  one-cycle pulse
- o_done  out  1  pulse on a Y8->Y9 step
- o_abort  out  1  pulse on an early return to Y0
- o_err  out  1  sticky illegal-step flag
- o_loop_cnt  out  LOOP_W  Y5->Y4 retries in the current pass
- o_loop_ovf  out  1  sticky; set when o_loop_cnt reaches MAX_LOOPS
- o_state  out  2  monitor FSM state: SYNC=0, TRACK=1, ERR=2

Behaviour:
- Reset values: every output is 0 and the FSM is in SYNC. The internal prev register is 0.
- All outputs are registered. Each response appears on the cycle after the sample it belongs to.
- Cycles with i_valid=0 are ignored entirely. prev holds its value and no pulses are produced.
- Legal steps: 0->1, 1->2, 1->4, 2->3, 3->7, 4->5, 5->6, 5->4, 6->8, 7->8, 8->9, 9->0.
- Codes 10..15 are always illegal.
- A code equal to prev is illegal, because the sequencer advances every clock.
- SYNC state:
  - Discards samples until code 0 arrives.
  - Code 0: prev<=0, o_loop_cnt<=0, go to TRACK.
- TRACK state, for each valid sample cur:
  - Legal step: prev<=cur.
  - prev=1: o_x1<=(cur==4) and o_x1_vld pulses.
  - prev=5: o_x2<=(cur==6) and o_x2_vld pulses.
    - On 5->4, o_loop_cnt increments, saturating at 2^LOOP_W-1.
    - o_loop_ovf sets when the incremented value equals MAX_LOOPS.
  - 8->9: o_done pulses.
  - 9->0: o_loop_cnt<=0 and the FSM stays in TRACK.
  - cur=0 from any prev other than 9: treated as an upstream reset, not an error. o_abort pulses, o_loop_cnt<=0, prev<=0, stay in TRACK.
  - Any other illegal step: o_err<=1 and go to ERR.
- ERR state:
  - Lasts exactly one cycle, then goes to SYNC.
  - Samples taken during ERR are discarded.
- i_err_clr:
  - Clears o_err and o_loop_ovf.
  - If a new error or overflow occurs in the same cycle, the set wins.
  - Has no effect on the FSM state.
- Reset asserted mid-operation forces the reset values immediately, regardless of the clock.

Optional Feature:
- Macro: SEQ_TRACE_ERR_CAPTURE_EN.
- When defined:
  - Adds output ports o_err_prev[3:0] and o_err_cur[3:0], both reset to 0.
  - They latch {prev, cur} of the first illegal step after reset or after i_err_clr.
  - Later errors do not overwrite them while o_err=1.
- When undefined: the ports and registers are absent. All other behaviour is identical.

Decomposition:
- Package seq_trace_pkg holds:
  - the state-code constants Y0..Y9 shared with the sequencer;
  - the monitor state encoding SYNC/TRACK/ERR;
  - a function is_legal_step(prev, cur).
- Sub-module seq_step_checker: combinational. Inputs prev and cur; outputs legal, early_zero, x1_step, x2_step, loop_step, done_step.
- The top level holds the FSM, counters and sticky flags.

Test Plan:
- Sync with X1=0: valid codes 5, 0,1,2,3,7,8,9,0 -> 5 is discarded. o_x1_vld pulses with o_x1=0 one cycle after code 2 is sampled. o_done pulses after 9. o_err=0 and o_loop_cnt=0 throughout.
- X1=1 path with three retries: 0,1,4,5,4,5,4,5,4,5,6,8,9 -> o_x1=1. o_x2_vld pulses four times with o_x2=0,0,0,1. o_loop_cnt=3, then 0 after the following 0.
- Illegal step: 0,1,3 -> o_err=1 and o_state goes to ERR for one cycle, then SYNC. A later 0 re-enters TRACK with o_err still 1. An i_err_clr pulse then clears o_err.
- Early zero: 0,1,4,5,0 -> o_abort pulses, o_err stays 0, o_loop_cnt=0.
- Gaps and bad codes: legal path with i_valid low between samples -> results identical to the ungapped run. Repeated code 2,2 -> o_err=1. Code 12 -> o_err=1. With SEQ_TRACE_ERR_CAPTURE_EN defined, o_err_prev=2 and o_err_cur=2 for the first error.
- Overflow: MAX_LOOPS=3, LOOP_W=2; four retries -> o_loop_ovf sets on the third retry and o_loop_cnt saturates at 3. Async i_rst asserted mid-path -> all outputs return to 0 without waiting for a clock edge.
